// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU and its control-side sequencer:
//   - alu_op_e    : ALU opcodes (OP_ADD..OP_CMP), also used by alu_8bit
//   - bit positions of the fields inside a 16-bit instruction word
//   - state_e     : sequencer FSM encoding (IDLE=0, EXEC=1, WB=2, LDW=3)
//   - instr_t     : decoded instruction, produced by decode()
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_MUL = 3'b101,
      OP_DIV = 3'b110,
      OP_CMP = 3'b111
   } alu_op_e;

   localparam int INSTR_W    = 16;
   localparam int LDI_BIT    = 15;
   // LDI fields
   localparam int LDI_RD_HI  = 12;
   localparam int LDI_RD_LO  = 11;
   localparam int IMM_HI     = 7;
   localparam int IMM_LO     = 0;
   // ALU fields
   localparam int OP_HI      = 14;
   localparam int OP_LO      = 12;
   localparam int RD_HI      = 11;
   localparam int RD_LO      = 10;
   localparam int RA_HI      = 9;
   localparam int RA_LO      = 8;
   localparam int RB_HI      = 7;
   localparam int RB_LO      = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2,
      ST_LDW  = 2'd3
   } state_e;

   typedef struct packed {
      logic       is_ldi;
      alu_op_e    op;
      logic [1:0] rd;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [7:0] imm;
   } instr_t;

   // The destination field sits in a different place for LDI and ALU words;
   // the other fields are extracted unconditionally and used only when relevant.
   function automatic instr_t decode(input logic [INSTR_W-1:0] w);
      instr_t d;
      d.is_ldi = w[LDI_BIT];
      d.op     = alu_op_e'(w[OP_HI:OP_LO]);
      d.rd     = w[LDI_BIT] ? w[LDI_RD_HI:LDI_RD_LO] : w[RD_HI:RD_LO];
      d.ra     = w[RA_HI:RA_LO];
      d.rb     = w[RB_HI:RB_LO];
      d.imm    = w[IMM_HI:IMM_LO];
      return d;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Instruction handshake between an instruction source and the sequencer.
//   in_valid : source -> sequencer, instruction word valid
//   in_ready : sequencer -> source, instruction can be accepted
//   in_instr : source -> sequencer, 16-bit instruction word
// Modports: master (instruction source), slave (sequencer).
// -----------------------------------------------------------------------------
interface alu_sequencer_if;
   import alu_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;

   modport master (output in_valid, output in_instr, input  in_ready);
   modport slave  (input  in_valid, input  in_instr, output in_ready);

endinterface

// File: rtl/regfile_4x8.sv
// -----------------------------------------------------------------------------
// regfile_4x8
// Four 8-bit registers: one synchronous write port, two combinational read
// ports for the ALU operands and one combinational debug read port.
//   clk, rst             : clock, asynchronous active-high reset (clears all)
//   we_i/waddr_i/wdata_i : write port
//   raddr_a_i/rdata_a_o  : operand A read port
//   raddr_b_i/rdata_b_o  : operand B read port
//   dbg_addr_i/dbg_data_o: debug read port
// -----------------------------------------------------------------------------
module regfile_4x8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       we_i,
   input  logic [1:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [1:0] raddr_a_i,
   input  logic [1:0] raddr_b_i,
   input  logic [1:0] dbg_addr_i,
   output logic [7:0] rdata_a_o,
   output logic [7:0] rdata_b_o,
   output logic [7:0] dbg_data_o
);

   logic [7:0] rf_q [4];

   // NOTE: only four registers, so a full async clear is cheap and gives
   // defined operands after reset; larger arrays would normally be left
   // unreset so they can map onto RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      end else if (we_i) begin
         rf_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o  = rf_q[raddr_a_i];
   assign rdata_b_o  = rf_q[raddr_b_i];
   assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Accepts one 16-bit instruction at a time, drives the combinational ALU from
// a 4x8 register file and writes the result and flags back.
//   clk, rst   : clock, asynchronous active-high reset
//   in_if      : instruction handshake (slave), in_ready high only in IDLE
//   alu_a/b    : registered ALU operands
//   alu_sel    : registered ALU opcode
//   alu_out    : ALU result,  carry_out: ALU carry/borrow/overflow/div-zero
//   done       : one-cycle pulse when an instruction retires
//   res_data   : value written by the last retired instruction
//   carry_flag : carry of the last ALU instruction (LDI leaves it alone)
//   zero_flag  : res_data == 0 for the last retired instruction
//   dbg_addr/dbg_data : combinational register file read
// Parameter SETTLE (1..4): cycles the ALU inputs are held before sampling.
// -----------------------------------------------------------------------------
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   alu_sequencer_if.slave    in_if,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [2:0]        alu_sel,
   input  logic [7:0]        alu_out,
   input  logic              carry_out,
   output logic              done,
   output logic [7:0]        res_data,
   output logic              carry_flag,
   output logic              zero_flag,
   input  logic [1:0]        dbg_addr,
   output logic [7:0]        dbg_data
);

   localparam logic [1:0] SETTLE_INIT = 2'(SETTLE - 1);

   state_e     state_q,   state_d;
   logic [1:0] cnt_q,     cnt_d;
   logic [1:0] rd_q,      rd_d;
   logic [7:0] imm_q,     imm_d;
   logic [7:0] alu_a_q,   alu_a_d;
   logic [7:0] alu_b_q,   alu_b_d;
   alu_op_e    alu_sel_q, alu_sel_d;
   logic       done_q,    done_d;
   logic [7:0] res_q,     res_d;
   logic       carry_q,   carry_d;
   logic       zero_q,    zero_d;

   instr_t     dec;
   logic       rf_we;
   logic [7:0] rf_wdata;
   logic [7:0] rf_rd_a;
   logic [7:0] rf_rd_b;

   assign dec = decode(in_if.in_instr);

   // Operand addresses come straight from the incoming word so the operands
   // are the register values at the transfer edge (old value when rd==ra/rb).
   regfile_4x8 u_rf (
      .clk        (clk),
      .rst        (rst),
      .we_i       (rf_we),
      .waddr_i    (rd_q),
      .wdata_i    (rf_wdata),
      .raddr_a_i  (dec.ra),
      .raddr_b_i  (dec.rb),
      .dbg_addr_i (dbg_addr),
      .rdata_a_o  (rf_rd_a),
      .rdata_b_o  (rf_rd_b),
      .dbg_data_o (dbg_data)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= OP_ADD;
         done_q    <= 1'b0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         imm_q     <= imm_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_sel_q <= alu_sel_d;
         done_q    <= done_d;
         res_q     <= res_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      imm_d     = imm_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      done_d    = 1'b0;
      res_d     = res_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      rf_we     = 1'b0;
      rf_wdata  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_if.in_valid) begin
               rd_d = dec.rd;
               if (dec.is_ldi) begin
                  imm_d   = dec.imm;
                  state_d = ST_LDW;
               end else begin
                  alu_a_d   = rf_rd_a;
                  alu_b_d   = rf_rd_b;
                  alu_sel_d = dec.op;
                  cnt_d     = SETTLE_INIT;
                  state_d   = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (cnt_q == 2'd0) state_d = ST_WB;
            else               cnt_d   = cnt_q - 2'd1;
         end
         ST_WB: begin
            rf_we    = 1'b1;
            rf_wdata = alu_out;
            res_d    = alu_out;
            carry_d  = carry_out;
            zero_d   = (alu_out == 8'd0);
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         ST_LDW: begin
            rf_we    = 1'b1;
            rf_wdata = imm_q;
            res_d    = imm_q;
            zero_d   = (imm_q == 8'd0);
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_if.in_ready = (state_q == ST_IDLE);
   assign alu_a          = alu_a_q;
   assign alu_b          = alu_b_q;
   assign alu_sel        = alu_sel_q;
   assign done           = done_q;
   assign res_data       = res_q;
   assign carry_flag     = carry_q;
   assign zero_flag      = zero_q;

endmodule
